// File: rtl/seq_mul16.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul16 (with CLA16bits)
// Brief    : Unsigned 16x16 -> 32-bit shift-add multiplier, one CLA add/cycle.
// Revision : 1.0 - initial release
// ============================================================================

module CLA16bits (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        c,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Group carries come only from group generate/propagate, never from the ripple.
    assign w_gc[0] = c;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & c);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & c);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & c);

    generate
        for (genvar k = 0; k < 4; k++) begin : g_grp
            localparam int C_B0 = 4 * k;
            logic [3:0] w_cl;

            assign w_cl[0] = w_gc[k];
            assign w_cl[1] = w_g[C_B0] | (w_p[C_B0] & w_gc[k]);
            assign w_cl[2] = w_g[C_B0+1] | (w_p[C_B0+1] & w_g[C_B0])
                           | (w_p[C_B0+1] & w_p[C_B0] & w_gc[k]);
            assign w_cl[3] = w_g[C_B0+2] | (w_p[C_B0+2] & w_g[C_B0+1])
                           | (w_p[C_B0+2] & w_p[C_B0+1] & w_g[C_B0])
                           | (w_p[C_B0+2] & w_p[C_B0+1] & w_p[C_B0] & w_gc[k]);

            assign w_gg[k] = w_g[C_B0+3] | (w_p[C_B0+3] & w_g[C_B0+2])
                           | (w_p[C_B0+3] & w_p[C_B0+2] & w_g[C_B0+1])
                           | (w_p[C_B0+3] & w_p[C_B0+2] & w_p[C_B0+1] & w_g[C_B0]);
            assign w_gp[k] = &w_p[C_B0+3:C_B0];

            assign sum[C_B0+3:C_B0] = w_p[C_B0+3:C_B0] ^ w_cl;
        end
    endgenerate

    assign cout = w_gc[4];

endmodule

module seq_mul16 #(
    parameter bit HOLD_PRODUCT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    // Encoding chosen so busy and done are direct state-register bits.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_m;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [4:0]  r_count;
    logic [31:0] r_product;

    logic [15:0] w_addend;
    logic [15:0] w_sum;
    logic        w_cout;
    logic [31:0] w_next_acc;
    logic        w_last_iter;

    assign w_addend    = r_lo[0] ? r_m : 16'h0000;
    assign w_next_acc  = {w_cout, w_sum, r_lo[15:1]};
    assign w_last_iter = (r_count == 5'd15);

    CLA16bits u_cla (
        .A    (r_hi),
        .B    (w_addend),
        .c    (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last_iter) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= 16'h0000;
            r_hi      <= 16'h0000;
            r_lo      <= 16'h0000;
            r_count   <= 5'd0;
            r_product <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= multiplicand;
                        r_lo    <= multiplier;
                        r_hi    <= 16'h0000;
                        r_count <= 5'd0;
                    end
                end
                S_RUN: begin
                    {r_hi, r_lo} <= w_next_acc;
                    r_count      <= r_count + 5'd1;
                    if (w_last_iter) begin
                        r_product <= w_next_acc;
                    end
                end
                S_DONE: begin
                    if (!HOLD_PRODUCT) begin
                        r_product <= 32'h0000_0000;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_state[1];
    assign done    = r_state[0];
    assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul16.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seq_mul16
// Brief    : Directed self-checking bench for seq_mul16 (both HOLD_PRODUCT modes).
// Revision : 1.0 - initial release
// ============================================================================

module tb_seq_mul16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy_h, done_h;
    logic [31:0] prod_h;
    logic        busy_c, done_c;
    logic [31:0] prod_c;

    int          n_checks;
    int          n_fail;
    logic [31:0] last_prod;
    int          done_cnt;

    seq_mul16 #(.HOLD_PRODUCT(1'b1)) u_dut_hold (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy_h),
        .done         (done_h),
        .product      (prod_h)
    );

    seq_mul16 #(.HOLD_PRODUCT(1'b0)) u_dut_clr (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy_c),
        .done         (done_c),
        .product      (prod_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation and check every cycle from E0 through E17.
    task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] q,
                          input logic [31:0] exp);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        step();
        chk({tag, " busy@E0"}, {31'b0, busy_h}, 32'd1);
        chk({tag, " done@E0"}, {31'b0, done_h}, 32'd0);
        start        = 1'b0;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk({tag, " busy run"}, {31'b0, busy_h}, 32'd1);
            chk({tag, " done run"}, {31'b0, done_h}, 32'd0);
            chk({tag, " prod run"}, prod_h, last_prod);
        end
        step();
        chk({tag, " done@E16"}, {31'b0, done_h}, 32'd1);
        chk({tag, " busy@E16"}, {31'b0, busy_h}, 32'd1);
        chk({tag, " product"},  prod_h, exp);
        chk({tag, " product clr"}, prod_c, exp);
        chk({tag, " done clr"}, {31'b0, done_c}, 32'd1);
        step();
        chk({tag, " busy@E17"}, {31'b0, busy_h}, 32'd0);
        chk({tag, " done@E17"}, {31'b0, done_h}, 32'd0);
        chk({tag, " held"},     prod_h, exp);
        chk({tag, " cleared"},  prod_c, 32'h0);
        last_prod = exp;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        done_cnt     = 0;
        last_prod    = 32'h0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = 16'h0;
        multiplier   = 16'h0;
        step();
        step();
        chk("reset busy",    {31'b0, busy_h}, 32'd0);
        chk("reset done",    {31'b0, done_h}, 32'd0);
        chk("reset product", prod_h, 32'h0);
        rst = 1'b0;
        step();
        chk("idle busy", {31'b0, busy_h}, 32'd0);

        run_op("3x5",        16'd3,    16'd5,    32'h0000_000F);
        run_op("FFFFxFFFF",  16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_op("0x1234",     16'h0000, 16'h1234, 32'h0000_0000);
        run_op("1234x0",     16'h1234, 16'h0000, 32'h0000_0000);
        run_op("8000x2",     16'h8000, 16'h0002, 32'h0001_0000);

        // Start while busy: at E5 and during DONE, both ignored.
        start = 1'b1; multiplicand = 16'd3; multiplier = 16'd5;
        step();
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 5) begin
                start = 1'b1; multiplicand = 16'd7; multiplier = 16'd7;
            end
            step();
            start = 1'b0;
            if (i < 16) chk("ignore busy", {31'b0, busy_h}, 32'd1);
        end
        chk("ignore done",    {31'b0, done_h}, 32'd1);
        chk("ignore product", prod_h, 32'h0000_000F);
        start = 1'b1; multiplicand = 16'd7; multiplier = 16'd7;
        step();
        start = 1'b0;
        chk("ignore busy@E17", {31'b0, busy_h}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_h) done_cnt++;
        end
        chk("no second done",  done_cnt, 32'd0);
        chk("no second busy",  {31'b0, busy_h}, 32'd0);
        chk("ignore prod end", prod_h, 32'h0000_000F);

        // Reset landing on iteration 7.
        start = 1'b1; multiplicand = 16'hFFFF; multiplier = 16'hFFFF;
        step();
        start = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        chk("midrst busy",     {31'b0, busy_h}, 32'd0);
        chk("midrst done",     {31'b0, done_h}, 32'd0);
        chk("midrst product",  prod_h, 32'h0);
        chk("midrst clr busy", {31'b0, busy_c}, 32'd0);
        rst = 1'b0;
        last_prod = 32'h0;
        run_op("00FFx0101", 16'h00FF, 16'h0101, 32'h0000_FFFF);

        // Start held high: accepted at E0 and E18, one done each.
        done_cnt = 0;
        start = 1'b1; multiplicand = 16'h1234; multiplier = 16'h5678;
        step();
        chk("b2b busy@E0", {31'b0, busy_h}, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (done_h) done_cnt++;
        end
        chk("b2b done@E16", {31'b0, done_h}, 32'd1);
        chk("b2b prod1",    prod_h, 32'h0626_0060);
        chk("b2b prod1 clr", prod_c, 32'h0626_0060);
        step();
        chk("b2b busy@E17", {31'b0, busy_h}, 32'd0);
        chk("b2b clr@E17",  prod_c, 32'h0);
        step();
        chk("b2b busy@E18", {31'b0, busy_h}, 32'd1);
        chk("b2b done@E18", {31'b0, done_h}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (done_h) done_cnt++;
        end
        start = 1'b0;
        chk("b2b prod2",    prod_h, 32'h0626_0060);
        step();
        chk("b2b done count", done_cnt, 32'd2);
        chk("b2b busy end",   {31'b0, busy_h}, 32'd0);
        chk("b2b clr end",    prod_c, 32'h0);
        chk("b2b held end",   prod_h, 32'h0626_0060);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
